sequence_checker: RTL and testbench

- Upstream stage of the game state machine in the memory game.
- Generates the growing random colour sequence and plays it on the four LEDs.
- Checks the player's switch presses against the sequence.
- Produces the level_complete, game_over_signal and win_signal pulses that the state machine consumes.

---
 rtl/game_pkg.sv | 23 ++
 rtl/lfsr8.sv | 26 ++
 rtl/sequence_checker.sv | 159 +++++++++++++++
 tb/tb_sequence_checker.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the memory-game sequence checker.
//   state_e        : FSM state encoding
//   LFSR_TAPS      : feedback tap mask for the 8-bit Fibonacci LFSR
//   colour_onehot  : 2-bit colour index -> one-hot LED/switch pattern
package game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GEN,
    SHOW_ON,
    SHOW_OFF,
    WAIT_INPUT,
    HALT
  } state_e;

  // x^8 + x^6 + x^5 + x^4 + 1, shifting left: feedback from bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [3:0] colour_onehot(input logic [1:0] c);
    colour_onehot = 4'b0001 << c;
  endfunction

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, loaded with SEED on reset.
//   clk      : clock
//   reset_n  : synchronous active-low reset
//   state_o  : current LFSR state
module lfsr8
  import game_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic [7:0] state_o
);

  logic [7:0] state_q, state_d;

  assign state_d = {state_q[6:0], ^(state_q & LFSR_TAPS)};

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= SEED;
    else          state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/sequence_checker.sv
// Memory-game sequence generator / checker.
// Grows a random colour sequence one element per level, plays it on the
// LEDs, then checks the player's switch presses against it.
//   clk, reset_n       : clock, synchronous active-low reset
//   play_en            : game running; low forces IDLE
//   switch1..switch4   : debounced switch levels (colour 0..3)
//   show_tick          : timebase pulse for display steps and timeout
//   led_out            : one-hot LED drive (sw mirror while waiting)
//   seq_len            : current sequence length
//   level_complete     : pulse, whole sequence entered correctly
//   game_over_signal   : pulse, wrong/multiple press or timeout
//   win_signal         : pulse with the final level_complete at MAX_LEN
module sequence_checker
  import game_pkg::*;
#(
  parameter int         MAX_LEN       = 16,
  parameter int         LEN_W         = 5,
  parameter logic [7:0] SEED          = 8'hA5,
  parameter int         TIMEOUT_TICKS = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             play_en,
  input  logic             switch1,
  input  logic             switch2,
  input  logic             switch3,
  input  logic             switch4,
  input  logic             show_tick,
  output logic [3:0]       led_out,
  output logic [LEN_W-1:0] seq_len,
  output logic             level_complete,
  output logic             game_over_signal,
  output logic             win_signal
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);

  state_e           state_q;
  logic [LEN_W-1:0] seq_len_q, idx_q;
  logic [TW-1:0]    timer_q;
  logic [1:0]       mem_q [MAX_LEN];
  logic [3:0]       sw_q, sw_qq;
  logic             lc_q, go_q, win_q;

  logic [7:0]       lfsr;
  logic [5:0]       lfsr_unused;
  logic [3:0]       edges, exp_oh;
  logic             last, at_max;

  lfsr8 #(.SEED(SEED)) u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .state_o (lfsr)
  );
  assign lfsr_unused = lfsr[7:2];

  // Two-stage switch capture; a press is a rising level between them.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sw_q  <= '0;
      sw_qq <= '0;
    end else begin
      sw_q  <= {switch4, switch3, switch2, switch1};
      sw_qq <= sw_q;
    end
  end

  assign edges  = sw_q & ~sw_qq;
  assign exp_oh = colour_onehot(mem_q[idx_q[AW-1:0]]);
  assign last   = (idx_q == seq_len_q - LEN_W'(1));
  assign at_max = (seq_len_q == LEN_W'(MAX_LEN));

  // Sequence storage: written only while generating, never cleared.
  always_ff @(posedge clk) begin
    if (reset_n && play_en && state_q == GEN)
      mem_q[seq_len_q[AW-1:0]] <= lfsr[1:0];
  end

  always_ff @(posedge clk) begin
    lc_q  <= 1'b0;
    go_q  <= 1'b0;
    win_q <= 1'b0;
    if (!reset_n || !play_en) begin
      state_q   <= IDLE;
      seq_len_q <= '0;
      idx_q     <= '0;
      timer_q   <= '0;
    end else begin
      case (state_q)
        IDLE: state_q <= GEN;
        GEN: begin
          seq_len_q <= seq_len_q + LEN_W'(1);
          idx_q     <= '0;
          state_q   <= SHOW_ON;
        end
        SHOW_ON: if (show_tick) state_q <= SHOW_OFF;
        SHOW_OFF: if (show_tick) begin
          if (last) begin
            idx_q   <= '0;
            timer_q <= '0;
            state_q <= WAIT_INPUT;
          end else begin
            idx_q   <= idx_q + LEN_W'(1);
            state_q <= SHOW_ON;
          end
        end
        WAIT_INPUT: begin
          // Any press is checked before the tick, so a press on the
          // timeout tick is still honoured. exp_oh is one-hot, so a
          // multi-switch press can never match.
          if (edges != '0) begin
            if (edges == exp_oh) begin
              timer_q <= '0;
              if (last) begin
                lc_q <= 1'b1;
                if (at_max) begin
                  win_q   <= 1'b1;
                  state_q <= HALT;
                end else begin
                  state_q <= GEN;
                end
              end else begin
                idx_q <= idx_q + LEN_W'(1);
              end
            end else begin
              go_q    <= 1'b1;
              state_q <= HALT;
            end
          end else if (show_tick) begin
            if (timer_q == TW'(TIMEOUT_TICKS - 1)) begin
              go_q    <= 1'b1;
              state_q <= HALT;
            end else begin
              timer_q <= timer_q + TW'(1);
            end
          end
        end
        HALT:    state_q <= HALT;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    led_out = '0;
    case (state_q)
      SHOW_ON:    led_out = exp_oh;
      WAIT_INPUT: led_out = sw_q;
      default:    led_out = '0;
    endcase
  end

  assign seq_len          = seq_len_q;
  assign level_complete   = lc_q;
  assign game_over_signal = go_q;
  assign win_signal       = win_q;

endmodule

// File: tb/tb_sequence_checker.sv
// Random-play bench: a scripted player drives switches from the reference
// model's view of the game; every cycle all outputs are compared against
// that model.
module tb_sequence_checker;

  localparam int         MAX_LEN = 4;
  localparam int         LEN_W   = 5;
  localparam int         TO      = 8;
  localparam logic [7:0] SEED    = 8'hA5;

  localparam int P_IDLE = 0, P_GEN = 1, P_ON = 2, P_OFF = 3, P_WAIT = 4, P_HALT = 5;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0, play_en = 1'b0, show_tick = 1'b0;
  logic             switch1 = 1'b0, switch2 = 1'b0, switch3 = 1'b0, switch4 = 1'b0;
  logic [3:0]       led_out;
  logic [LEN_W-1:0] seq_len;
  logic             level_complete, game_over_signal, win_signal;

  always #5 clk = ~clk;

  sequence_checker #(
    .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .SEED(SEED), .TIMEOUT_TICKS(TO)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .play_en          (play_en),
    .switch1          (switch1),
    .switch2          (switch2),
    .switch3          (switch3),
    .switch4          (switch4),
    .show_tick        (show_tick),
    .led_out          (led_out),
    .seq_len          (seq_len),
    .level_complete   (level_complete),
    .game_over_signal (game_over_signal),
    .win_signal       (win_signal)
  );

  int vecs = 0, errs = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    vecs++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_q[$];        // the colour sequence so far
  int         m_ph = P_IDLE;
  int         m_pos = 0, m_ticks = 0;
  logic [7:0] m_lfsr = SEED;
  logic [3:0] m_sw1 = '0, m_sw2 = '0;
  bit         m_lc = 0, m_go = 0, m_win = 0;
  int         m_wins = 0, d_wins = 0;
  bit         armed = 0;

  always @(posedge clk) begin
    logic [3:0] pr;
    logic [7:0] lf;
    pr = m_sw1 & ~m_sw2;
    lf = m_lfsr;
    m_lc = 0; m_go = 0; m_win = 0;
    if (!reset_n) begin
      m_lfsr = SEED;
      m_sw1 = '0; m_sw2 = '0;
      m_q.delete(); m_ph = P_IDLE; m_pos = 0; m_ticks = 0;
    end else begin
      m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
      m_sw2 = m_sw1;
      m_sw1 = {switch4, switch3, switch2, switch1};
      if (!play_en) begin
        m_q.delete(); m_ph = P_IDLE; m_pos = 0; m_ticks = 0;
      end else begin
        case (m_ph)
          P_IDLE: m_ph = P_GEN;
          P_GEN: begin
            m_q.push_back(int'(lf[1:0]));
            m_pos = 0; m_ph = P_ON;
          end
          P_ON: if (show_tick) m_ph = P_OFF;
          P_OFF: if (show_tick) begin
            if (m_pos + 1 == m_q.size()) begin
              m_pos = 0; m_ticks = 0; m_ph = P_WAIT;
            end else begin
              m_pos++; m_ph = P_ON;
            end
          end
          P_WAIT: begin
            if (pr != 0) begin
              if ($countones(pr) == 1 && pr[m_q[m_pos]]) begin
                m_ticks = 0;
                if (m_pos + 1 < m_q.size()) m_pos++;
                else begin
                  m_lc = 1;
                  if (m_q.size() == MAX_LEN) begin
                    m_win = 1; m_wins++; m_ph = P_HALT;
                  end else m_ph = P_GEN;
                end
              end else begin
                m_go = 1; m_ph = P_HALT;
              end
            end else if (show_tick) begin
              m_ticks++;
              if (m_ticks == TO) begin
                m_go = 1; m_ph = P_HALT;
              end
            end
          end
          default: ;
        endcase
      end
    end
    armed = 1;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [3:0] el;
    if (armed) begin
      el = '0;
      if (m_ph == P_ON)   el = 4'b0001 << m_q[m_pos];
      if (m_ph == P_WAIT) el = m_sw1;
      chk("led_out", int'(led_out), int'(el));
      chk("seq_len", int'(seq_len), m_q.size());
      chk("level_complete", int'(level_complete), int'(m_lc));
      chk("game_over", int'(game_over_signal), int'(m_go));
      chk("win", int'(win_signal), int'(m_win));
      if (win_signal) d_wins++;
    end
  end

  // ---------------- stimulus / player ----------------
  initial begin
    int         tcnt, hold, gap, plan, c, d;
    logic [3:0] sw;
    tcnt = 0; hold = 0; gap = 0; plan = -1; sw = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 play_en = 1'b1;
    for (int cyc = 0; cyc < 25000; cyc++) begin
      @(posedge clk); #1;
      tcnt = (tcnt + 1) % 10;
      show_tick = (tcnt == 9);

      if (!reset_n) reset_n = 1'b1;
      else if ($urandom_range(0, 999) == 0) reset_n = 1'b0;
      if (!play_en) begin
        if ($urandom_range(0, 3) == 0) play_en = 1'b1;
      end else if (m_ph == P_HALT && $urandom_range(0, 15) == 0) play_en = 1'b0;
      else if ($urandom_range(0, 499) == 0) play_en = 1'b0;

      if (m_ph != P_WAIT) plan = -1;
      if (hold > 0) begin
        hold--;
        if (hold == 0) begin
          sw = '0;
          gap = $urandom_range(1, 12);
        end
      end else if (gap > 0) begin
        gap--;
      end else if (m_ph == P_WAIT && m_sw1 == 0) begin
        if (plan < 0) plan = $urandom_range(0, 99);
        c = m_q[m_pos];
        if (plan < 5) begin
          // correct press landing on the timeout tick
          if (m_ticks == TO - 1 && tcnt == 8) sw = 4'b0001 << c;
        end else if (plan < 8) begin
          sw = 4'b0001 << ((c + 1 + $urandom_range(0, 2)) % 4);
        end else if (plan < 10) begin
          d = (c + 1 + $urandom_range(0, 2)) % 4;
          sw = (4'b0001 << c) | (4'b0001 << d);
        end else if (plan < 13) begin
          sw = '0;  // sit idle until timeout
        end else begin
          sw = 4'b0001 << c;
        end
        if (sw != 0) begin
          hold = $urandom_range(1, 4);
          plan = -1;
        end
      end
      {switch4, switch3, switch2, switch1} = sw;
    end
    {switch4, switch3, switch2, switch1} = 4'b0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("win_count", d_wins, m_wins);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
